// File: rtl/adc128s102_responder.sv
// Chip-side model of the ADC128S102 serial link: takes CS_L/SCLK/DIN from the
// ADC controller and returns 16-bit frames {4'h0, word[ch]} on DOUT.
module adc128s102_responder #(
  parameter logic IDLE_DOUT = 1'b0
) (
  input  logic        X_512x96k_1024x48k_Clk,
  input  logic        sres,
  input  logic        X_ADC_CS_L,
  input  logic        X_ADC_Clock,
  input  logic        X_ADC_SerDat_Send_d,
  input  logic [95:0] X_Emu_Channel_Words,
  output logic        X_ADC_SerDat_Return,
  output logic [2:0]  X_Emu_Current_Channel,
  output logic        X_Emu_Frame_Done_pulse,
  output logic        X_Emu_Frame_Error_pulse
);

  localparam int DATA_W = 12;
  localparam logic [4:0] BITS_PER_FRAME = 5'd16;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic cs_p0_q, cs_p1_q, sclk_p0_q, sclk_p1_q, din_p0_q;
  logic cs_fall, cs_rise, sclk_fall, sclk_rise;

  logic [0:0]  state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  rise_cnt_q, rise_cnt_d;
  logic [4:0]  fall_cnt_q, fall_cnt_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  next_ch_q, next_ch_d;
  logic [2:0]  cur_ch_q, cur_ch_d;
  logic        dout_q, dout_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  function automatic logic [DATA_W-1:0] chan_word(input logic [8*DATA_W-1:0] words,
                                                  input logic [2:0] ch);
    chan_word = words[ch*DATA_W +: DATA_W];
  endfunction

  // p0: pin capture; p1: previous value for edge detection
  always_ff @(posedge X_512x96k_1024x48k_Clk) begin
    if (sres) begin
      cs_p0_q   <= 1'b0;
      cs_p1_q   <= 1'b0;
      sclk_p0_q <= 1'b0;
      sclk_p1_q <= 1'b0;
    end else begin
      cs_p0_q   <= X_ADC_CS_L;
      cs_p1_q   <= cs_p0_q;
      sclk_p0_q <= X_ADC_Clock;
      sclk_p1_q <= sclk_p0_q;
    end
  end

  always_ff @(posedge X_512x96k_1024x48k_Clk) begin
    din_p0_q <= X_ADC_SerDat_Send_d;
  end

  assign cs_fall   = cs_p1_q & ~cs_p0_q;
  assign cs_rise   = ~cs_p1_q & cs_p0_q;
  assign sclk_fall = sclk_p1_q & ~sclk_p0_q;
  assign sclk_rise = ~sclk_p1_q & sclk_p0_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    addr_d     = addr_q;
    next_ch_d  = next_ch_q;
    cur_ch_d   = cur_ch_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // A CS_L fall starts a frame from either state; in ACTIVE it is a glitch restart
    if (cs_fall) begin
      state_d    = ST_ACTIVE;
      sr_d       = {4'h0, chan_word(X_Emu_Channel_Words, next_ch_q)};
      cur_ch_d   = next_ch_q;
      rise_cnt_d = 5'd0;
      fall_cnt_d = 5'd0;
      dout_d     = 1'b0;
    end else if (state_q == ST_ACTIVE) begin
      if (cs_rise) begin
        state_d = ST_IDLE;
        dout_d  = IDLE_DOUT;
        if (rise_cnt_q == BITS_PER_FRAME && fall_cnt_q == BITS_PER_FRAME) begin
          next_ch_d = addr_q;
          done_d    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        if (sclk_fall && fall_cnt_q != BITS_PER_FRAME) begin
          fall_cnt_d = fall_cnt_q + 5'd1;
          if (fall_cnt_q == BITS_PER_FRAME - 5'd1) begin
            dout_d = IDLE_DOUT;
          end else begin
            sr_d   = {sr_q[14:0], sr_q[15]};
            dout_d = sr_q[14];
          end
        end
        if (sclk_rise && rise_cnt_q != BITS_PER_FRAME) begin
          rise_cnt_d = rise_cnt_q + 5'd1;
          case (rise_cnt_q)
            5'd2:    addr_d[2] = din_p0_q;
            5'd3:    addr_d[1] = din_p0_q;
            5'd4:    addr_d[0] = din_p0_q;
            default: addr_d    = addr_q;
          endcase
        end
      end
    end
  end

  // Frame control state
  always_ff @(posedge X_512x96k_1024x48k_Clk) begin
    if (sres) begin
      state_q    <= ST_IDLE;
      rise_cnt_q <= 5'd0;
      fall_cnt_q <= 5'd0;
      next_ch_q  <= 3'd0;
      cur_ch_q   <= 3'd0;
      dout_q     <= IDLE_DOUT;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      next_ch_q  <= next_ch_d;
      cur_ch_q   <= cur_ch_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge X_512x96k_1024x48k_Clk) begin
    sr_q   <= sr_d;
    addr_q <= addr_d;
  end

  assign X_ADC_SerDat_Return     = dout_q;
  assign X_Emu_Current_Channel   = cur_ch_q;
  assign X_Emu_Frame_Done_pulse  = done_q;
  assign X_Emu_Frame_Error_pulse = err_q;

endmodule

// File: tb/tb_adc128s102_responder.sv
// Bench for adc128s102_responder: a controller model drives frames, expected
// frame outcomes are queued and a monitor checks them at each end-of-frame pulse.
module tb_adc128s102_responder;

  logic        clk = 1'b0;
  logic        sres;
  logic        cs_l;
  logic        sclk;
  logic        din;
  logic [95:0] words;
  logic        dout;
  logic [2:0]  cur_ch;
  logic        done_p;
  logic        err_p;

  always #5 clk = ~clk;

  adc128s102_responder dut (
    .X_512x96k_1024x48k_Clk (clk),
    .sres                   (sres),
    .X_ADC_CS_L             (cs_l),
    .X_ADC_Clock            (sclk),
    .X_ADC_SerDat_Send_d    (din),
    .X_Emu_Channel_Words    (words),
    .X_ADC_SerDat_Return    (dout),
    .X_Emu_Current_Channel  (cur_ch),
    .X_Emu_Frame_Done_pulse (done_p),
    .X_Emu_Frame_Error_pulse(err_p)
  );

  typedef struct {
    logic        is_err;
    logic [2:0]  ch;
    logic [11:0] word;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] rxq[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic is_err, input logic [2:0] ch, input logic [11:0] w);
    exp_t e;
    e.is_err = is_err;
    e.ch     = ch;
    e.word   = w;
    expq.push_back(e);
  endtask

  task automatic set_word(input int n, input logic [11:0] w);
    words[12*n +: 12] = w;
  endtask

  // Controller model: 4 clk per SCLK period, DIN changes on SCLK fall,
  // DOUT sampled one clk before each SCLK fall.
  task automatic run_frame(input logic [2:0] sel, input int ncyc,
                           input int rst_bit, input int chg_bit);
    logic [15:0] ctl;
    logic [15:0] rx;
    ctl = {2'b00, sel, 11'b0};
    rx  = 16'h0;
    cs_l = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < ncyc; i++) begin
      rx[15-i] = dout;
      tick();
      sclk = 1'b0;
      din  = ctl[15-i];
      if (i == chg_bit) set_word(0, 12'hEEE);
      tick();
      if (i == rst_bit) chk("pre_reset_dout", 32'(dout), 32'd1);
      tick();
      sclk = 1'b1;
      if (i == rst_bit) begin
        sres = 1'b1;
        tick();
        sres = 1'b0;
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_ch", 32'(cur_ch), 32'd0);
        chk("reset_pulses", 32'({done_p, err_p}), 32'd0);
      end else begin
        tick();
      end
    end
    if (rst_bit < 0) rxq.push_back(rx);
    tick();
    cs_l = 1'b1;
    din  = 1'b0;
    repeat (6) tick();
  endtask

  always @(negedge clk) begin
    if (done_p || err_p) begin
      exp_t        e;
      logic [15:0] rx;
      chk("pulse_exclusive", 32'(done_p & err_p), 32'd0);
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 32'({done_p, err_p}), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("frame_error", 32'(err_p), 32'(e.is_err));
        chk("frame_done", 32'(done_p), 32'(!e.is_err));
        chk("current_channel", 32'(cur_ch), 32'(e.ch));
        if (rxq.size() == 0) begin
          chk("rx_available", 32'd0, 32'd1);
        end else begin
          rx = rxq.pop_front();
          if (!e.is_err) chk("rx_word", 32'(rx), 32'({4'h0, e.word}));
        end
      end
    end
  end

  initial begin
    int prev;
    sres  = 1'b1;
    cs_l  = 1'b1;
    sclk  = 1'b1;
    din   = 1'b0;
    words = '0;
    repeat (3) tick();
    sres = 1'b0;
    tick();
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ch", 32'(cur_ch), 32'd0);
    chk("rst_done", 32'(done_p), 32'd0);
    chk("rst_err", 32'(err_p), 32'd0);
    repeat (4) tick();

    set_word(0, 12'hA5C);
    set_word(5, 12'h3F1);
    expect_frame(1'b0, 3'd0, 12'hA5C);
    run_frame(3'd5, 16, -1, -1);
    expect_frame(1'b0, 3'd5, 12'h3F1);
    run_frame(3'd0, 16, -1, -1);

    for (int n = 0; n < 8; n++) set_word(n, 12'(12'h101 * n));
    prev = 0;
    for (int s = 7; s >= 0; s--) begin
      expect_frame(1'b0, 3'(prev), 12'(12'h101 * prev));
      run_frame(3'(s), 16, -1, -1);
      prev = s;
    end
    expect_frame(1'b0, 3'd0, 12'h000);
    run_frame(3'd4, 16, -1, -1);

    expect_frame(1'b1, 3'd4, 12'h000);
    run_frame(3'd3, 9, -1, -1);
    expect_frame(1'b0, 3'd4, 12'h404);
    run_frame(3'd6, 16, -1, -1);

    set_word(6, 12'h6C6);
    set_word(0, 12'h111);
    run_frame(3'd2, 16, 8, -1);
    expect_frame(1'b0, 3'd0, 12'h111);
    run_frame(3'd0, 16, -1, 5);
    expect_frame(1'b0, 3'd0, 12'hEEE);
    run_frame(3'd0, 16, -1, -1);

    repeat (10) tick();
    chk("pending_expectations", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
